// File: rtl/dt_arbiter_pkg.sv
// Shared definitions for the dt packet arbiter: default widths, header tag,
// FSM state encoding and the packet-to-byte count helper.
package dt_arbiter_pkg;

    localparam int unsigned DEF_DATA_PACKET_WIDTH = 51;
    localparam int unsigned DEF_UART_DATA_WIDTH   = 8;
    localparam logic [3:0]  DEF_HDR_TAG           = 4'hA;

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StLoad,
        StHdr,
        StSend
    } arb_state_e;

    function automatic int unsigned calc_nbytes(input int unsigned dpw, input int unsigned udw);
        return (dpw + udw - 1) / udw;
    endfunction

endpackage

// File: rtl/dt_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr_i,
// wrapping past N_SRC-1 back to 0.
module dt_rr_arbiter #(
    parameter int unsigned N_SRC = 4
) (
    input  logic [N_SRC-1:0]         req_i,
    input  logic [$clog2(N_SRC)-1:0] ptr_i,
    output logic [$clog2(N_SRC)-1:0] gnt_idx_o,
    output logic                     gnt_vld_o
);

    localparam int unsigned IdxW = $clog2(N_SRC);

    logic [2*N_SRC-1:0] req_rot;
    logic [IdxW-1:0]    offset;
    logic [IdxW:0]      sum;

    always_comb begin
        req_rot = {req_i, req_i} >> ptr_i;
        offset  = '0;
        // Scan downwards so the lowest rotated position wins.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = IdxW'(i);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, offset};
        if (sum >= (IdxW + 1)'(N_SRC)) begin
            sum = sum - (IdxW + 1)'(N_SRC);
        end
        gnt_idx_o = sum[IdxW-1:0];
        gnt_vld_o = |req_i;
    end

endmodule

// File: rtl/dt_arbiter.sv
// Round-robin arbiter that pops one packet from a non-empty dt FIFO and
// serialises it as a header byte plus MSB-first packet bytes to the UART.
module dt_arbiter
    import dt_arbiter_pkg::*;
#(
    parameter int unsigned N_SRC             = 4,
    parameter int unsigned DATA_PACKET_WIDTH = DEF_DATA_PACKET_WIDTH,
    parameter int unsigned UART_DATA_WIDTH   = DEF_UART_DATA_WIDTH,
    parameter logic [3:0]  HDR_TAG           = DEF_HDR_TAG
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic [N_SRC-1:0]                     f_empty,
    input  logic [N_SRC*DATA_PACKET_WIDTH-1:0]   data_packet,
    output logic [N_SRC-1:0]                     rd_en,
    output logic [UART_DATA_WIDTH-1:0]           data_byte,
    output logic                                 we,
    input  logic                                 tx_ready,
    output logic                                 busy,
    output logic [$clog2(N_SRC)-1:0]             grant_id
);

    localparam int unsigned IdxW   = $clog2(N_SRC);
    localparam int unsigned NBYTES = calc_nbytes(DATA_PACKET_WIDTH, UART_DATA_WIDTH);
    localparam int unsigned ShW    = NBYTES * UART_DATA_WIDTH;
    localparam int unsigned CntW   = $clog2(NBYTES + 1);

    arb_state_e             state_q, state_d;
    logic [IdxW-1:0]        grant_q, grant_d;
    logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                   busy_q, busy_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [ShW-1:0]         shreg_q, shreg_d;

    logic [IdxW-1:0]              pick_idx;
    logic                         pick_vld;
    logic [DATA_PACKET_WIDTH-1:0] pkt_sel;

    dt_rr_arbiter #(
        .N_SRC (N_SRC)
    ) u_rr (
        .req_i     (~f_empty),
        .ptr_i     (rr_ptr_q),
        .gnt_idx_o (pick_idx),
        .gnt_vld_o (pick_vld)
    );

    always_comb begin
        pkt_sel = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q == IdxW'(i)) begin
                pkt_sel = data_packet[i*DATA_PACKET_WIDTH +: DATA_PACKET_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        rd_en     = '0;
        we        = 1'b0;
        data_byte = '0;

        unique case (state_q)
            StIdle: begin
                if (en && pick_vld) begin
                    grant_d = pick_idx;
                    busy_d  = 1'b1;
                    state_d = StPop;
                end
            end
            StPop: begin
                rd_en   = N_SRC'(1) << grant_q;
                state_d = StLoad;
            end
            StLoad: begin
                // FIFO data is valid the cycle after the pop strobe.
                shreg_d                        = '0;
                shreg_d[DATA_PACKET_WIDTH-1:0] = pkt_sel;
                state_d                        = StHdr;
            end
            StHdr: begin
                we        = 1'b1;
                data_byte = UART_DATA_WIDTH'({HDR_TAG, 4'(grant_q)});
                if (tx_ready) begin
                    cnt_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                we        = 1'b1;
                data_byte = shreg_q[ShW-1 -: UART_DATA_WIDTH];
                if (tx_ready) begin
                    shreg_d = shreg_q << UART_DATA_WIDTH;
                    if (cnt_q == CntW'(NBYTES - 1)) begin
                        busy_d   = 1'b0;
                        state_d  = StIdle;
                        rr_ptr_d = (grant_q == IdxW'(N_SRC - 1)) ? '0 : grant_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            shreg_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
        end
    end

    assign busy     = busy_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_dt_arbiter.sv
// Scoreboard bench for dt_arbiter: stimulus queues expected grants and bytes,
// a negedge monitor compares whatever the DUT presents.
module tb_dt_arbiter;

    localparam int N   = 4;
    localparam int DPW = 51;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             tx_ready;
    logic [N-1:0]     f_empty = '1;
    logic [N*DPW-1:0] data_packet = '0;
    logic [N-1:0]     rd_en;
    logic [7:0]       data_byte;
    logic             we;
    logic             busy;
    logic [1:0]       grant_id;

    dt_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .f_empty     (f_empty),
        .data_packet (data_packet),
        .rd_en       (rd_en),
        .data_byte   (data_byte),
        .we          (we),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int xfer_cnt = 0;
    int exp_grant[$];
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // FIFO model: one shared queue tagged by source, read latency of one cycle.
    typedef struct {
        int         src;
        logic [50:0] data;
    } ent_t;
    ent_t        fq[$];
    logic        push_vld = 1'b0;
    int          push_src = 0;
    logic [50:0] push_data = '0;
    logic [N-1:0] pop_req = '0;

    always @(negedge clk) pop_req <= rd_en;

    always @(posedge clk) begin
        bit emp;
        if (push_vld) fq.push_back('{push_src, push_data});
        for (int i = 0; i < N; i++) begin
            if (pop_req[i]) begin
                for (int k = 0; k < fq.size(); k++) begin
                    if (fq[k].src == i) begin
                        data_packet[i*DPW +: DPW] <= fq[k].data;
                        fq.delete(k);
                        break;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            emp = 1'b1;
            for (int k = 0; k < fq.size(); k++) if (fq[k].src == i) emp = 1'b0;
            f_empty[i] <= emp;
        end
    end

    // Monitor: grants and bytes are compared against the scoreboard queues.
    always @(negedge clk) begin
        int g;
        if (rst) begin
            check("rst_rd_en", rd_en, 0);
            check("rst_we", we, 0);
            check("rst_busy", busy, 0);
            check("rst_data_byte", data_byte, 0);
            check("rst_grant_id", grant_id, 0);
        end else begin
            if (rd_en != '0) begin
                check("rd_en_onehot", 32'($onehot(rd_en)), 1);
                if (exp_grant.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL rd_en_unexpected: got %b, required 0000", rd_en);
                end else begin
                    g = exp_grant.pop_front();
                    check("grant_id", grant_id, g);
                    check("rd_en", rd_en, 32'(1) << g);
                    check("pop_nonempty", f_empty[g], 0);
                end
            end
            if (we) begin
                check("busy_while_we", busy, 1);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL byte_unexpected: got %0h, required none", data_byte);
                end else begin
                    check("data_byte", data_byte, exp_q[0]);
                    if (tx_ready) void'(exp_q.pop_front());
                end
                if (tx_ready) xfer_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input int src, input logic [50:0] d);
        push_src  = src;
        push_data = d;
        push_vld  = 1'b1;
        tick();
        push_vld  = 1'b0;
    endtask

    task automatic expect_pkt(input int src, input logic [50:0] d, input int nb);
        logic [55:0] ext;
        ext = {5'b0, d};
        exp_grant.push_back(src);
        exp_q.push_back(8'hA0 | 8'(src));
        for (int k = 0; k < nb; k++) exp_q.push_back(ext[(6-k)*8 +: 8]);
    endtask

    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 800 && !done; c++) begin
            tick();
            if (exp_q.size() == 0 && exp_grant.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: got %0d bytes pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic wait_xfer(input string name, input int target);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            tick();
            if (xfer_cnt >= target) done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: got %0d transfers, required %0d", name, xfer_cnt, target);
        end
    endtask

    task automatic wait_we(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            tick();
            if (we) done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: got we=0, required we=1", name);
        end
    endtask

    localparam logic [50:0] PKT_A = 51'h5_1234_5678_9ABC;
    logic [7:0] t1_bytes [8] = '{8'hA2, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    logic [50:0] t4_pkts [3] = '{51'h7_FFFF_FFFF_FFFF, 51'h0_0000_0000_0001, 51'h2_AAAA_5555_00FF};

    initial begin
        int base;
        logic [50:0] d;
        rst = 1'b1;
        en = 1'b1;
        tx_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Single packet from source 2, literal byte stream.
        exp_grant.push_back(2);
        for (int k = 0; k < 8; k++) exp_q.push_back(t1_bytes[k]);
        push_pkt(2, PKT_A);
        wait_done("t1");
        check("t1_busy_end", busy, 0);

        // Backpressure on header and on packet byte 4.
        base = xfer_cnt;
        tx_ready = 1'b0;
        expect_pkt(2, PKT_A, 7);
        push_pkt(2, PKT_A);
        wait_we("t2_hdr");
        repeat (3) tick();
        tx_ready = 1'b1;
        wait_xfer("t2_b4", base + 5);
        tx_ready = 1'b0;
        repeat (3) tick();
        tx_ready = 1'b1;
        wait_done("t2");

        // Sole requester at source 3 is regranted across the pointer wrap.
        en = 1'b0;
        for (int p = 0; p < 3; p++) begin
            expect_pkt(3, t4_pkts[p], 7);
            push_pkt(3, t4_pkts[p]);
        end
        en = 1'b1;
        wait_done("t4");

        // Fairness: two packets per source, strict rotation from pointer 0.
        en = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < N; s++) begin
                d = {3'(s), 8'(r + 1), 40'h13_579B_DF02};
                expect_pkt(s, d, 7);
                push_pkt(s, d);
            end
        end
        en = 1'b1;
        wait_done("t3");

        // en falls after the header: packet completes, then no grants until en returns.
        en = 1'b0;
        base = xfer_cnt;
        expect_pkt(1, 51'h1_0F0F_F0F0_1234, 7);
        push_pkt(1, 51'h1_0F0F_F0F0_1234);
        push_pkt(2, 51'h6_DEAD_BEEF_CAFE);
        en = 1'b1;
        wait_xfer("t5_hdr", base + 1);
        en = 1'b0;
        wait_done("t5a");
        repeat (20) tick();
        check("t5_hold_busy", busy, 0);
        check("t5_hold_we", we, 0);
        expect_pkt(2, 51'h6_DEAD_BEEF_CAFE, 7);
        en = 1'b1;
        wait_done("t5b");

        // Reset while byte 3 is presented; pointer restarts at 0.
        base = xfer_cnt;
        expect_pkt(1, 51'h3_1111_2222_3333, 3);
        push_pkt(1, 51'h3_1111_2222_3333);
        push_pkt(1, 51'h4_4444_5555_6666);
        push_pkt(3, 51'h0_7777_8888_9999);
        wait_xfer("t6_b3", base + 4);
        rst = 1'b1;
        #1;
        check("t6_rst_we", we, 0);
        check("t6_rst_rd_en", rd_en, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_data_byte", data_byte, 0);
        check("t6_rst_grant_id", grant_id, 0);
        expect_pkt(1, 51'h4_4444_5555_6666, 7);
        expect_pkt(3, 51'h0_7777_8888_9999, 7);
        repeat (2) tick();
        rst = 1'b0;
        wait_done("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end

endmodule

// File: doc/dt_arbiter.md
Name: dt_arbiter

Overview:
- Shares one UART byte channel between N_SRC clock-domain-crossed packet FIFOs, each holding DATA_PACKET_WIDTH-bit packets.
- Round-robin selects a non-empty FIFO, pops one packet and emits it as a header byte followed by the packet bytes, MSB-first, over a valid/ready byte handshake.
- Sits on the read-clock side, between the per-source dt FIFOs and the UART transmitter.

Parameters:
- N_SRC, 4, number of requesting FIFOs (2..16)
- DATA_PACKET_WIDTH, 51, packet width in bits
- UART_DATA_WIDTH, 8, output byte width
- HDR_TAG, 4'hA, upper nibble of the header byte

Ports:
- clk  input  1  read-side clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  arbitration enable; low blocks new grants only
- f_empty  input  N_SRC  per-FIFO empty flags
- data_packet  input  N_SRC*DATA_PACKET_WIDTH  flattened FIFO read data; source i occupies [i*DPW +: DPW]
- rd_en  output  N_SRC  one-hot FIFO pop strobe
- data_byte  output  UART_DATA_WIDTH  byte to transmitter
- we  output  1  byte valid
- tx_ready  input  1  transmitter accepts the byte
- busy  output  1  high from grant until the last byte is accepted
- grant_id  output  $clog2(N_SRC)  source currently served

Behaviour:
- Reset (async, rst=1): the FSM goes to IDLE; rd_en=0, we=0, data_byte=0, busy=0, grant_id=0, rr_ptr=0. All are cleared on the rst edge, mid-packet included. A packet already popped at that point is dropped, and its remaining bytes are never sent.
- NBYTES = ceil(DPW/8) = 7 at defaults. The packet is zero-extended to NBYTES*8 = 56 bits. Packet byte k (k=0..NBYTES-1) is ext[(NBYTES-1-k)*8 +: 8], so byte0 = {5'b0, pkt[50:48]}.
- Header byte = {HDR_TAG, grant_id zero-extended to 4 bits}.
- FSM states and transitions:
  - IDLE: if en=1 and any f_empty bit is 0, pick the first non-empty source searching from rr_ptr upward with wrap-around. Latch grant_id, set busy=1, go to POP. Otherwise stay.
  - POP: rd_en[grant_id]=1 for exactly one cycle; go to LOAD.
  - LOAD: FIFO read latency is 1 cycle. Capture the data_packet slice of the granted source into the shift register; go to HDR.
  - HDR: we=1, data_byte=header. On we&&tx_ready go to SEND with byte counter = 0.
  - SEND: we=1, data_byte=packet byte[cnt]. On a transfer: if cnt==NBYTES-1, go to IDLE, set busy=0, rr_ptr=(grant_id+1) mod N_SRC; else cnt+1.
- Handshake rules:
  - data_byte stays stable while we=1 and tx_ready=0.
  - we never drops before a transfer.
  - tx_ready is ignored while we=0.
  - Back-to-back transfers are allowed, one byte per cycle.
- Latency: f_empty falling in IDLE -> rd_en high the next cycle. Header we rises 2 cycles after rd_en. With tx_ready tied high a packet takes 1+1+1+NBYTES+1 = 11 cycles from grant to IDLE.
- Boundary cases:
  - f_empty changes during service are ignored; only one packet is served per grant.
  - All sources non-empty: strict rotation 0,1,2,3,0...
  - Only the source at rr_ptr-1 requests: it is granted again (wrap-around).
  - en falls mid-packet: the packet completes, then the block holds in IDLE.
  - Popping an empty FIFO is impossible because the grant is based on the flag sampled in IDLE.
  - N_SRC not a power of two: the rr_ptr wrap is explicit, never modulo by truncation.

Decomposition:
- Shared package/header (periplex.vh): DATA_PACKET_WIDTH, UART_DATA_WIDTH, HDR_TAG, state encodings (IDLE/POP/LOAD/HDR/SEND), NBYTES computation.
- One sub-module: dt_rr_arbiter, a combinational round-robin picker. Inputs: request vector and rr_ptr. Outputs: grant index and grant-valid.
- The FSM and serializer stay in dt_arbiter.

Test Plan:
- Single packet: source 2 holds 51'h5_1234_5678_9ABC, tx_ready=1 -> rd_en=4'b0100 for 1 cycle. Bytes: A2,05,12,34,56,78,9A,BC. busy low after the 8th byte; rr_ptr=3.
- Backpressure: same packet, tx_ready low for 3 cycles on the header and on byte 4 -> data_byte stays stable, we stays high, byte order unchanged, no extra rd_en.
- Fairness: all 4 FIFOs hold 2 packets each -> grant order 0,1,2,3,0,1,2,3; exactly 8 rd_en pulses, each one-hot.
- Wrap and sole requester: only source 3 non-empty with 3 packets -> granted 3 times, header A3 each time.
- en gating: en deasserted after the header of source 1 -> all 8 bytes complete; no new rd_en while en=0; service resumes at source 2 when en=1.
- Reset mid-packet: rst pulse at byte 3 -> we, rd_en, busy, data_byte and grant_id are 0 immediately. After release, the next non-empty source (from 0) is served with a full header and 7 bytes.
